// File: rtl/ifu_cache_pkg.sv
// Shared definitions for the instruction-fetch cache.
// Holds the default geometry constants and the pseudo-LRU tree helpers
// (victim selection and access-path update). The helpers work on a tree
// padded to the widest supported size and take the tree depth as an
// argument, so smaller caches zero-extend their tree and truncate results.
package ifu_cache_pkg;

  localparam int DEF_NUM_TAGS     = 16;
  localparam int DEF_NUM_LINES    = 16;
  localparam int DEF_TAG_WIDTH    = 30;
  localparam int DEF_LINE_WIDTH   = 128;
  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_OFFSET_WIDTH = 4;

  // Widest tree the helpers handle: 64 ways, 63 internal nodes.
  localparam int PLRU_MAX_LEVELS = 6;
  localparam int PLRU_MAX_BITS   = (1 << PLRU_MAX_LEVELS) - 1;
  localparam int PLRU_WAY_W      = PLRU_MAX_LEVELS;
  localparam int PLRU_NODE_W     = PLRU_MAX_LEVELS + 1;

  // Walk from the root following each node bit (0 = left, 1 = right).
  function automatic logic [PLRU_WAY_W-1:0] plru_victim(
    input logic [PLRU_MAX_BITS-1:0] tree,
    input int                       levels
  );
    logic [PLRU_NODE_W-1:0] node;
    node = '0;
    for (int l = 0; l < PLRU_MAX_LEVELS; l++) begin
      if (l < levels) begin
        node = (node << 1) + PLRU_NODE_W'(1) + PLRU_NODE_W'(tree[node[PLRU_WAY_W-1:0]]);
      end
    end
    // Leaves are numbered after the internal nodes.
    return PLRU_WAY_W'(node - PLRU_NODE_W'((1 << levels) - 1));
  endfunction

  // Point every node on the path of `way` away from it: a left child
  // (odd node index) makes its parent point right, and vice versa.
  function automatic logic [PLRU_MAX_BITS-1:0] plru_update(
    input logic [PLRU_MAX_BITS-1:0] tree,
    input logic [PLRU_WAY_W-1:0]    way,
    input int                       levels
  );
    logic [PLRU_MAX_BITS-1:0] t;
    logic [PLRU_NODE_W-1:0]   node;
    logic [PLRU_NODE_W-1:0]   parent;
    t    = tree;
    node = PLRU_NODE_W'(way) + PLRU_NODE_W'((1 << levels) - 1);
    for (int l = 0; l < PLRU_MAX_LEVELS; l++) begin
      if (l < levels) begin
        parent                     = (node - PLRU_NODE_W'(1)) >> 1;
        t[parent[PLRU_WAY_W-1:0]]  = node[0];
        node                       = parent;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/ifu_plru_tree.sv
// Tree pseudo-LRU state for a fully associative set of NUM_LINES ways.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   hit_valid_i    lookup hit this cycle on way hit_way_i
//   fill_valid_i   fill write this cycle into way fill_way_i
//   victim_o       replacement way from the tree state before this edge
//   tree_o         raw tree bits, node 0 is the root
module ifu_plru_tree
  import ifu_cache_pkg::*;
#(
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int WAY_W     = $clog2(NUM_LINES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 hit_valid_i,
  input  logic [WAY_W-1:0]     hit_way_i,
  input  logic                 fill_valid_i,
  input  logic [WAY_W-1:0]     fill_way_i,
  output logic [WAY_W-1:0]     victim_o,
  output logic [NUM_LINES-2:0] tree_o
);

  localparam int BITS = NUM_LINES - 1;

  logic [BITS-1:0] tree_q;
  logic [BITS-1:0] tree_d;

  assign victim_o = WAY_W'(plru_victim(PLRU_MAX_BITS'(tree_q), WAY_W));
  assign tree_o   = tree_q;

  // The fill update is applied after the hit update so it wins on shared nodes.
  always_comb begin
    // NOTE: start from the held value so every path assigns tree_d and no latch is inferred.
    tree_d = tree_q;
    if (hit_valid_i) begin
      tree_d = BITS'(plru_update(PLRU_MAX_BITS'(tree_d), PLRU_WAY_W'(hit_way_i), WAY_W));
    end
    if (fill_valid_i) begin
      tree_d = BITS'(plru_update(PLRU_MAX_BITS'(tree_d), PLRU_WAY_W'(fill_way_i), WAY_W));
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) tree_q <= '0;
    else       tree_q <= tree_d;
  end

endmodule

// File: rtl/ifu_cache.sv
// Fully associative instruction-fetch cache with tree pseudo-LRU replacement.
// Every cycle the fetch address is looked up against the arrays as they were
// before the edge; the response and any miss request are registered.
// Ports:
//   Clock, Rst                 clock, synchronous active-high reset
//   cpu_reqAddrIn              fetch address (valid every cycle)
//   cpu_rspAddrOut             address belonging to the registered response
//   cpu_rspInsLineOut          line of the last hit (holds across misses)
//   cpu_rspInsLineValidOut     registered hit flag
//   mem_rspTagIn/InsLineIn/ValidIn  fill from memory, one strobe per line
//   mem_reqTagOut/ValidOut     registered miss request
//   debug_*                    direct views of the arrays and PLRU tree
module ifu_cache
  import ifu_cache_pkg::*;
#(
  parameter int NUM_TAGS     = DEF_NUM_TAGS,
  parameter int NUM_LINES    = DEF_NUM_LINES,
  parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
  parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic [ADDR_WIDTH-1:0] cpu_reqAddrIn,
  output logic [ADDR_WIDTH-1:0] cpu_rspAddrOut,
  output logic [LINE_WIDTH-1:0] cpu_rspInsLineOut,
  output logic                  cpu_rspInsLineValidOut,
  input  logic [TAG_WIDTH-1:0]  mem_rspTagIn,
  input  logic [LINE_WIDTH-1:0] mem_rspInsLineIn,
  input  logic                  mem_rspInsLineValidIn,
  output logic [TAG_WIDTH-1:0]  mem_reqTagOut,
  output logic                  mem_reqTagValidOut,
  output logic [LINE_WIDTH-1:0] debug_dataArray [NUM_LINES],
  output logic [TAG_WIDTH-1:0]  debug_tagArray  [NUM_TAGS],
  output logic [NUM_TAGS-1:0]   debug_validArray,
  output logic [NUM_LINES-2:0]  debug_plruTree
);

  localparam int WAY_W = $clog2(NUM_LINES);

  logic [LINE_WIDTH-1:0] data_q [NUM_LINES];
  logic [TAG_WIDTH-1:0]  tag_q  [NUM_TAGS];
  logic [NUM_TAGS-1:0]   valid_q;

  logic [ADDR_WIDTH-1:0] rsp_addr_q;
  logic [LINE_WIDTH-1:0] rsp_line_q;
  logic                  rsp_valid_q;
  logic [TAG_WIDTH-1:0]  req_tag_q;
  logic                  req_valid_q;

  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic                  fill_match;
  logic [WAY_W-1:0]      match_way;
  logic                  found_inv;
  logic [WAY_W-1:0]      inv_way;
  logic [WAY_W-1:0]      victim_way;
  logic [WAY_W-1:0]      fill_way;

  assign req_tag = TAG_WIDTH'(cpu_reqAddrIn[ADDR_WIDTH-1:OFFSET_WIDTH]);

  // Tags are unique among valid entries, so at most one way matches each search.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    fill_match = 1'b0;
    match_way  = '0;
    found_inv  = 1'b0;
    inv_way    = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (valid_q[i] && tag_q[i] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
      if (valid_q[i] && tag_q[i] == mem_rspTagIn) begin
        fill_match = 1'b1;
        match_way  = WAY_W'(i);
      end
      if (!valid_q[i] && !found_inv) begin
        found_inv = 1'b1;
        inv_way   = WAY_W'(i);
      end
    end
    // Refill of a resident tag overwrites in place; otherwise first free way, then PLRU.
    if (fill_match)     fill_way = match_way;
    else if (found_inv) fill_way = inv_way;
    else                fill_way = victim_way;
  end

  ifu_plru_tree #(
    .NUM_LINES (NUM_LINES),
    .WAY_W     (WAY_W)
  ) u_plru (
    .clk_i        (Clock),
    .rst_i        (Rst),
    .hit_valid_i  (hit),
    .hit_way_i    (hit_way),
    .fill_valid_i (mem_rspInsLineValidIn),
    .fill_way_i   (fill_way),
    .victim_o     (victim_way),
    .tree_o       (debug_plruTree)
  );

  always_ff @(posedge Clock) begin
    if (Rst) begin
      // NOTE: the arrays are plain flops and a reset must discard every line, so they are cleared here too.
      valid_q <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      rsp_addr_q  <= '0;
      rsp_line_q  <= '0;
      rsp_valid_q <= 1'b0;
      req_tag_q   <= '0;
      req_valid_q <= 1'b0;
    end else begin
      rsp_addr_q  <= cpu_reqAddrIn;
      rsp_valid_q <= hit;
      if (hit) rsp_line_q <= data_q[hit_way];
      req_valid_q <= !hit;
      if (!hit) req_tag_q <= req_tag;
      // A fill only becomes visible to lookups from the next edge.
      if (mem_rspInsLineValidIn) begin
        valid_q[fill_way] <= 1'b1;
        tag_q[fill_way]   <= mem_rspTagIn;
        data_q[fill_way]  <= mem_rspInsLineIn;
      end
    end
  end

  assign cpu_rspAddrOut         = rsp_addr_q;
  assign cpu_rspInsLineOut      = rsp_line_q;
  assign cpu_rspInsLineValidOut = rsp_valid_q;
  assign mem_reqTagOut          = req_tag_q;
  assign mem_reqTagValidOut     = req_valid_q;
  assign debug_dataArray        = data_q;
  assign debug_tagArray         = tag_q;
  assign debug_validArray       = valid_q;

endmodule

// File: tb/tb_ifu_cache.sv
// Scoreboard bench for ifu_cache: the driver pushes the hand-computed
// response for each cycle it issues; a negedge monitor pops and compares.
module tb_ifu_cache;

  logic          Clock = 1'b0;
  logic          Rst;
  logic [31:0]   cpu_reqAddrIn;
  logic [31:0]   cpu_rspAddrOut;
  logic [127:0]  cpu_rspInsLineOut;
  logic          cpu_rspInsLineValidOut;
  logic [29:0]   mem_rspTagIn;
  logic [127:0]  mem_rspInsLineIn;
  logic          mem_rspInsLineValidIn;
  logic [29:0]   mem_reqTagOut;
  logic          mem_reqTagValidOut;
  logic [127:0]  dbg_data [16];
  logic [29:0]   dbg_tag  [16];
  logic [15:0]   dbg_valid;
  logic [14:0]   dbg_plru;

  ifu_cache dut (
    .Clock                  (Clock),
    .Rst                    (Rst),
    .cpu_reqAddrIn          (cpu_reqAddrIn),
    .cpu_rspAddrOut         (cpu_rspAddrOut),
    .cpu_rspInsLineOut      (cpu_rspInsLineOut),
    .cpu_rspInsLineValidOut (cpu_rspInsLineValidOut),
    .mem_rspTagIn           (mem_rspTagIn),
    .mem_rspInsLineIn       (mem_rspInsLineIn),
    .mem_rspInsLineValidIn  (mem_rspInsLineValidIn),
    .mem_reqTagOut          (mem_reqTagOut),
    .mem_reqTagValidOut     (mem_reqTagValidOut),
    .debug_dataArray        (dbg_data),
    .debug_tagArray         (dbg_tag),
    .debug_validArray       (dbg_valid),
    .debug_plruTree         (dbg_plru)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int           due;
    logic [31:0]  addr;
    logic         v;
    logic [127:0] line;
    logic         mv;
    logic [29:0]  mt;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input int i);
    return {4{32'hA000_0000 | 32'(i)}};
  endfunction

  // Monitor: compares the DUT response for the cycle whose edge just passed.
  always @(negedge Clock) begin
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("rsp_addr", 128'(cpu_rspAddrOut), 128'(e.addr));
      check("rsp_valid", 128'(cpu_rspInsLineValidOut), 128'(e.v));
      if (e.v) check("rsp_line", cpu_rspInsLineOut, e.line);
      check("req_valid", 128'(mem_reqTagValidOut), 128'(e.mv));
      if (e.mv) check("req_tag", 128'(mem_reqTagOut), 128'(e.mt));
    end
  end

  // Drive one cycle at posedge+1 and record what must appear after the next edge.
  task automatic step(input logic [31:0] addr, input logic fv, input logic [29:0] ft,
                      input logic [127:0] fl, input logic ev, input logic [127:0] el,
                      input logic emv, input logic [29:0] emt);
    exp_t e;
    cpu_reqAddrIn         = addr;
    mem_rspInsLineValidIn = fv;
    mem_rspTagIn          = ft;
    mem_rspInsLineIn      = fl;
    e.due = cyc + 1; e.addr = addr; e.v = ev; e.line = el; e.mv = emv; e.mt = emt;
    sb.push_back(e);
    @(posedge Clock); #1;
    mem_rspInsLineValidIn = 1'b0;
  endtask

  localparam logic [127:0] L_DEAD = {4{32'hDEADBEEF}};
  localparam logic [127:0] L_FFF  = {4{32'h0FFF_0FFF}};
  localparam logic [127:0] L_300  = {4{32'h3333_3333}};
  localparam logic [127:0] L_5N   = {4{32'h5555_AAAA}};
  localparam logic [127:0] L_400  = {4{32'h4444_4444}};

  initial begin
    // Reset held two edges while a fill and lookup are presented: both ignored.
    Rst = 1'b1;
    cpu_reqAddrIn = 32'h1234;
    mem_rspInsLineValidIn = 1'b1;
    mem_rspTagIn = 30'h55;
    mem_rspInsLineIn = '1;
    @(posedge Clock); @(posedge Clock); #1;
    check("rst_rsp_addr", 128'(cpu_rspAddrOut), 128'h0);
    check("rst_rsp_valid", 128'(cpu_rspInsLineValidOut), 128'h0);
    check("rst_rsp_line", cpu_rspInsLineOut, 128'h0);
    check("rst_req_valid", 128'(mem_reqTagValidOut), 128'h0);
    check("rst_req_tag", 128'(mem_reqTagOut), 128'h0);
    check("rst_valid_arr", 128'(dbg_valid), 128'h0);
    check("rst_plru", 128'(dbg_plru), 128'h0);
    check("rst_tag0", 128'(dbg_tag[0]), 128'h0);
    Rst = 1'b0;
    mem_rspInsLineValidIn = 1'b0;

    // Miss and fill in the same cycle, then hit.
    step(32'h1000, 1'b1, 30'h100, L_DEAD, 1'b0, '0, 1'b1, 30'h100);
    check("fill1_valid_arr", 128'(dbg_valid), 128'h1);
    check("fill1_plru", 128'(dbg_plru), 128'h008B);
    step(32'h1000, 1'b0, '0, '0, 1'b1, L_DEAD, 1'b0, '0);

    // Mid-operation reset discards contents; first lookup misses.
    Rst = 1'b1;
    @(posedge Clock); #1;
    Rst = 1'b0;
    check("rst2_valid_arr", 128'(dbg_valid), 128'h0);
    step(32'h1000, 1'b0, '0, '0, 1'b0, '0, 1'b1, 30'h100);

    // Sixteen fills land in ways 0..15; in-order access leaves the tree at 0.
    for (int i = 0; i < 16; i++)
      step(32'h2000 + 32'(i) * 16, 1'b1, 30'h200 + 30'(i), line_of(i), 1'b0, '0, 1'b1, 30'h200 + 30'(i));
    check("full_valid_arr", 128'(dbg_valid), 128'hFFFF);
    check("full_plru", 128'(dbg_plru), 128'h0);
    for (int i = 0; i < 16; i++) check($sformatf("tag_way%0d", i), 128'(dbg_tag[i]), 128'(30'h200 + 30'(i)));
    for (int i = 0; i < 16; i++)
      step(32'h2000 + 32'(i) * 16, 1'b0, '0, '0, 1'b1, line_of(i), 1'b0, '0);
    check("hits_plru", 128'(dbg_plru), 128'h0);

    // Full cache, tree 0: new tag replaces way 0.
    step(32'hFFFF, 1'b1, 30'hFFF, L_FFF, 1'b0, '0, 1'b1, 30'hFFF);
    check("victim0_tag", 128'(dbg_tag[0]), 128'hFFF);
    check("victim0_plru", 128'(dbg_plru), 128'h008B);
    step(32'hFFFF, 1'b0, '0, '0, 1'b1, L_FFF, 1'b0, '0);

    // Tree after way-0 access points at way 8.
    step(32'h3000, 1'b1, 30'h300, L_300, 1'b0, '0, 1'b1, 30'h300);
    check("victim8_tag", 128'(dbg_tag[8]), 128'h300);
    check("victim8_plru", 128'(dbg_plru), 128'h08AE);
    step(32'h2080, 1'b0, '0, '0, 1'b0, '0, 1'b1, 30'h208);
    step(32'h3000, 1'b0, '0, '0, 1'b1, L_300, 1'b0, '0);

    // Refill of resident tag 0x205: same-cycle hit sees old data, overwrite in place.
    step(32'h2050, 1'b1, 30'h205, L_5N, 1'b1, line_of(5), 1'b0, '0);
    check("refill_valid_arr", 128'(dbg_valid), 128'hFFFF);
    check("refill_tag5", 128'(dbg_tag[5]), 128'h205);
    check("refill_data5", dbg_data[5], L_5N);
    check("refill_data6", dbg_data[6], line_of(6));
    check("refill_plru", 128'(dbg_plru), 128'h08BD);
    step(32'h2050, 1'b0, '0, '0, 1'b1, L_5N, 1'b0, '0);

    // Hit on way 1 with a fill to victim way 12: fill wins on the root node.
    step(32'h2010, 1'b1, 30'h400, L_400, 1'b1, line_of(1), 1'b0, '0);
    check("both_tag12", 128'(dbg_tag[12]), 128'h400);
    check("both_plru", 128'(dbg_plru), 128'h287A);

    @(negedge Clock); #1;
    check("scoreboard_drained", 128'(sb.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_cache.md
IFU_CACHE -- requirements
Module: ifu_cache

Interface
REQ-001 Parameters SHALL be: NUM_TAGS 16, tag entries; NUM_LINES 16, data lines (equal to NUM_TAGS, power of 2); TAG_WIDTH 30, stored tag width; LINE_WIDTH 128, line width; ADDR_WIDTH 32, address width; OFFSET_WIDTH 4, byte-offset bits.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 Clock  in  1  rising-edge clock.
REQ-004 Rst  in  1  synchronous active-high reset.
REQ-005 cpu_reqAddrIn  in  ADDR_WIDTH  fetch address, valid every cycle.
REQ-006 cpu_rspAddrOut  out  ADDR_WIDTH  address of the registered response.
REQ-007 cpu_rspInsLineOut  out  LINE_WIDTH  registered line on hit.
REQ-008 cpu_rspInsLineValidOut  out  1  registered hit flag.
REQ-009 mem_rspTagIn  in  TAG_WIDTH  tag of fill line.
REQ-010 mem_rspInsLineIn  in  LINE_WIDTH  fill data.
REQ-011 mem_rspInsLineValidIn  in  1  fill strobe, one cycle per fill.
REQ-012 mem_reqTagOut  out  TAG_WIDTH  miss tag to memory.
REQ-013 mem_reqTagValidOut  out  1  miss request strobe.
REQ-014 debug_dataArray[NUM_LINES], debug_tagArray[NUM_TAGS], debug_validArray[NUM_TAGS], debug_plruTree[NUM_LINES-2:0]  out  direct views of internal state.

Function
REQ-015 Fully associative; request tag = cpu_reqAddrIn[ADDR_WIDTH-1:OFFSET_WIDTH] zero-extended to TAG_WIDTH.
REQ-016 Lookup SHALL compare against array state before the current edge; hit = any valid entry with equal tag (at most one).
REQ-017 At each non-reset edge: cpu_rspAddrOut<=cpu_reqAddrIn; cpu_rspInsLineValidOut<=hit; cpu_rspInsLineOut<=hit line, else holds previous value.
REQ-018 On miss: mem_reqTagValidOut<=1, mem_reqTagOut<=request tag; on hit mem_reqTagValidOut<=0 (tag holds); one-cycle latency.
REQ-019 Fill (mem_rspInsLineValidIn=1): if mem_rspTagIn already valid, overwrite that entry's data; else write lowest-index invalid entry; else PLRU victim; set valid, tag, data.
REQ-020 Fill write is visible to lookups from the next edge; same-cycle miss on the filled tag still returns valid 0.
REQ-021 PLRU: binary tree, node 0 root, children 2n+1/2n+2, leaves = ways 0..NUM_LINES-1 left to right; bit 0 = victim in left (lower) subtree, 1 = right.
REQ-022 Victim = leaf reached by following bits from root.
REQ-023 On access to way w, every node on w's path SHALL be set to point away from w.
REQ-024 Hit updates PLRU for hit way; fill updates for written way; both in same cycle: hit update first, fill update applied last (fill wins on shared nodes).
REQ-025 No other state changes without hit or fill.

Reset
REQ-026 Rst=1 at an edge SHALL clear valid array, PLRU tree, tag and data arrays, cpu_rspAddrOut, cpu_rspInsLineOut, cpu_rspInsLineValidOut, mem_reqTagOut, mem_reqTagValidOut to 0; fills and lookups in that cycle are ignored.
REQ-027 Reset mid-operation discards all contents; first post-reset lookup misses.

Structure
REQ-028 Shared package ifu_cache_pkg SHALL hold default parameter constants and PLRU helper functions (victim select, path update).
REQ-029 One sub-module natural: ifu_plru_tree (state, victim output, access update inputs); rest in ifu_cache. Target 120-400 RTL lines.

Verification
REQ-030 Rst held 2 cycles -> debug_validArray=0, debug_plruTree=0, all outputs 0.
REQ-031 Addr 0x1000, fill DEADBEEF x4 tag 0x100 same cycle -> next cycle valid 0, mem_reqTagValidOut=1 tag 0x100; following cycle same addr -> valid 1, line DEADBEEF x4.
REQ-032 Fill 16 distinct tags into empty cache -> ways 0..15 in order, all valid; then each addr hits with its data.
REQ-033 Full cache, PLRU=0, fill new tag 0xFFF (addr 0xFFFF) -> victim way 0 replaced, same-cycle response valid 0; next cycle hit.
REQ-034 Hit way 0 -> plru nodes 0,1,3,7 = 1; victim becomes way 8.
REQ-035 Fill with tag already present -> no new entry, data overwritten in place.
